// File: rtl/pipe_valid_chain.sv
// Chain of STAGES payload registers, each with its own valid bit and a valid/ready handshake at
// both ends. A global stall freezes the chain and a per-stage flush kills selected occupants.
// An empty or killed stage accepts new data even when the stages after it are blocked, so bubbles
// collapse. A registered occupancy count tracks how many stages hold live payload.
module pipe_valid_chain #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4,
    parameter int unsigned CNT_W  = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    input  logic              stall,
    input  logic              flush,
    input  logic [STAGES-1:0] flush_mask,
    output logic [CNT_W-1:0]  occupancy,
    output logic              empty
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [CNT_W-1:0]  occ_q, occ_d;

    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] kv;
    logic [STAGES:0]   rdy;
    logic              in_fire;
    logic              out_fire;

    // Apply the kill mask, then ripple ready from the output back toward the input.
    always_comb begin
        kill        = flush ? flush_mask : '0;
        kv          = valid_q & ~kill;
        rdy[STAGES] = out_ready & ~stall;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~stall & (~kv[k] | rdy[k + 1]);
        end
    end

    // Input is never taken in a flush cycle; out_valid drops combinationally on stall or kill.
    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = kv[STAGES-1] & ~stall;
    assign out_data  = data_q[STAGES-1];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);

    // Next-state for valids and payloads: a ready stage takes its upstream, a blocked one holds.
    always_comb begin
        valid_d = kv;
        data_d  = data_q;
        if (rdy[0]) begin
            valid_d[0] = in_fire;
            if (in_fire) begin
                data_d[0] = in_data;
            end
        end
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) begin
                valid_d[k] = kv[k-1];
                if (kv[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Occupancy moves by accepted input, emitted output and killed live stages.
    always_comb begin
        occ_d = occ_q + CNT_W'(in_fire) - CNT_W'(out_fire)
              - CNT_W'($countones(valid_q & kill));
    end

    // State registers; reset clears everything, including payloads already in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    occ_matches_valids: assert property (
        @(posedge clk) disable iff (!reset_n) occ_q == CNT_W'($countones(valid_q))
    );

endmodule

// File: doc/pipe_valid_chain.md
Name: pipe_valid_chain

Overview:
- Parametrised successor to the fixed, always-loading pipeline stage registers used between IF/ID/EXE/MEM/WB.
- Chains STAGES data registers of WIDTH bits, each with its own valid bit, using a valid/ready handshake at both ends.
- Adds global stall (memory not responded), per-stage selective flush (branch/jump kill), bubble collapsing and an occupancy count.
- Sits between any two pipeline partitions; the CPU top uses one instance per inter-stage boundary group.

Parameters:
- WIDTH, 32, payload bits per stage
- STAGES, 4, number of register stages (≥1)
- CNT_W, $clog2(STAGES+1), occupancy counter width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream has payload
- in_ready  output  1  chain accepts payload this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  stage STAGES-1 holds live payload
- out_ready  input  1  downstream consumes
- out_data  output  WIDTH  payload of stage STAGES-1
- stall  input  1  freeze entire chain (e.g. !cmem_resp)
- flush  input  1  apply flush_mask this cycle
- flush_mask  input  STAGES  bit k kills current occupant of stage k
- occupancy  output  CNT_W  number of live stages
- empty  output  1  occupancy == 0

Behaviour:
- Reset (async, reset_n=0): all valid_q[k]=0, data_q[k]=0, occupancy=0; out_valid=0, out_data=0, empty=1. Takes effect immediately, mid-transfer included; no payload survives.
- Kill mask: kv[k] = valid_q[k] & ~(flush & flush_mask[k]).
- Ready chain: rdy[STAGES] = out_ready & ~stall; rdy[k] = ~stall & (~kv[k] | rdy[k+1]).
- Empty-stage rule: an empty or killed stage accepts even if downstream is blocked (bubble collapse).
- Ports:
  - in_ready = rdy[0] & ~flush; input is never accepted during a flush cycle.
  - out_valid = kv[STAGES-1] & ~stall (combinational from flush/stall by design; only sanctioned case of out_valid dropping without a transfer).
  - out_data = data_q[STAGES-1].
- Per-edge update, stage k:
  - if rdy[k]: valid_q[k] <= (k==0 ? in_valid & in_ready : kv[k-1]); data_q[k] loads its source when that source is valid, otherwise holds.
  - else: valid_q[k] <= kv[k]; data holds.
- Stall: everything holds; in_ready=0; out_valid=0. Flush still kills during stall (killed valids clear at the edge).
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- occupancy <= occupancy + in_fire − out_fire − popcount(valid_q & flush_mask & {STAGES{flush}}). Must always equal popcount(valid_q); mismatch is an assertion failure.
- Latency: payload accepted at edge t reaches out_valid after edge t+STAGES−1, i.e. STAGES cycles from acceptance, with no stall.
- Throughput: one payload per cycle sustained while out_ready=1 and no stall.
- Full: occupancy==STAGES and out_ready=0 → in_ready=0. Full with out_ready=1 → in_ready=1 (simultaneous in/out).
- Flushing the output stage while out_ready=1: no out_fire, payload discarded.
- flush with flush_mask=0 is a no-op except that in_ready is forced low that cycle.
- STAGES=1: single register; in_ready = ~stall & ~flush & (~kv[0] | out_ready).

Test Plan:
- Reset mid-stream: fill STAGES=4 with 0xA0..0xA3, pulse reset_n low asynchronously between edges → out_valid, occupancy and all valids 0 immediately; first payload after release appears 4 cycles after acceptance.
- Streaming: out_ready=1, in_data=1,2,3,… every cycle → out_data=1 at cycle 4, then one value per cycle in order, occupancy steady at 4.
- Back-pressure/full: out_ready=0, push 6 payloads → only 4 accepted, in_ready=0 from cycle 4, occupancy=4; raise out_ready → 5th accepted the same cycle 0x.. is emitted; order preserved.
- Bubble collapse: insert gaps (valid every 3rd cycle) with out_ready=0 → payloads compact to stages 3,2,1,0; occupancy counts 1..4.
- Selective flush: stages hold 10,11,12,13 (13 at output), flush=1, flush_mask=4'b0011 → 10 and 11 killed, in_ready=0 that cycle, occupancy 4→2, output later yields 13,12 only.
- Stall with concurrent flush: stall=1 for 3 cycles holding 4 payloads → no movement, out_valid=0; flush_mask=4'b1000 during stall → output payload removed, occupancy 3; on release, remaining 3 drain in order.
